rom_loader: RTL

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_pkg.sv | 25 ++
 rtl/rom_loader_fifo.sv | 50 +++++
 rtl/rom_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM download loader.
package rom_loader_pkg;

    localparam int         FIFO_DEPTH_DEF = 4;
    localparam logic [7:0] PAD_BYTE       = 8'h00;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } iss_state_t;

    // One FIFO entry: word address [23:1] plus the assembled 16-bit word.
    typedef struct packed {
        logic [22:0] addr;
        logic [15:0] data;
    } rom_word_t;

    // Place the even/odd bytes of a word according to the byte order option.
    function automatic logic [15:0] pack_word(input logic [7:0] even,
                                              input logic [7:0] odd,
                                              input logic       swap);
        return swap ? {odd, even} : {even, odd};
    endfunction

endpackage

// File: rtl/rom_loader_fifo.sv
// Small synchronous word FIFO with occupancy count; depth is a power of two.
module rom_loader_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 39
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Assembles an ioctl byte stream into 16-bit words and writes them to the
// SDRAM controller ROM port via a toggle req/ack handshake.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter bit BYTE_SWAP  = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic        romwr_req,
    input  logic        romwr_ack,
    output logic [22:0] romwr_a,
    output logic [15:0] romwr_d,
    output logic [22:0] rom_end,
    output logic        loading,
    output logic        load_done
);
    localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  WAIT_LVL = CW'(FIFO_DEPTH - 2);

    logic          pend_vld, pend_vld_n;
    logic [22:0]   pend_a, pend_a_n;
    logic [7:0]    pend_d, pend_d_n;
    // Second word of a flush+new pair, pushed the following cycle.
    logic          extra_vld, extra_vld_n;
    rom_word_t     extra_w, extra_w_n;
    logic          dl_q;

    logic          push_req, push_ok, pop;
    rom_word_t     push_w, head_w, flush_w;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty, fifo_full;
    iss_state_t    state;
    logic          byte_ok, ld_now;
    logic [22:0]   wa, end_base;

    assign wa       = ioctl_addr[23:1];
    assign byte_ok  = ioctl_wr & ~ioctl_addr[24];
    assign flush_w  = {pend_a, pack_word(pend_d, PAD_BYTE, BYTE_SWAP)};
    assign push_ok  = push_req & ~fifo_full;
    assign pop      = (state == IDLE) & ~fifo_empty & (romwr_req == romwr_ack);
    assign ioctl_wait = (fifo_cnt >= WAIT_LVL) | extra_vld;
    assign ld_now   = ioctl_download | ~fifo_empty | pend_vld | extra_vld | (state == WAIT_ACK);
    assign end_base = (ioctl_download & ~dl_q) ? '0 : rom_end;

    // Byte assembler: decide this cycle's FIFO push and next pending/extra state.
    always_comb begin
        push_req    = 1'b0;
        push_w      = extra_w;
        pend_vld_n  = pend_vld;
        pend_a_n    = pend_a;
        pend_d_n    = pend_d;
        extra_vld_n = 1'b0;
        extra_w_n   = extra_w;
        if (extra_vld) begin
            // Any byte strobed now is dropped; ioctl_wait was high.
            push_req    = 1'b1;
            push_w      = extra_w;
            extra_vld_n = fifo_full;
        end else if (byte_ok && !fifo_full) begin
            if (!ioctl_addr[0]) begin
                push_req   = pend_vld;
                push_w     = flush_w;
                pend_vld_n = 1'b1;
                pend_a_n   = wa;
                pend_d_n   = ioctl_data;
            end else if (pend_vld && pend_a == wa) begin
                push_req   = 1'b1;
                push_w     = {wa, pack_word(pend_d, ioctl_data, BYTE_SWAP)};
                pend_vld_n = 1'b0;
            end else begin
                push_req   = 1'b1;
                pend_vld_n = 1'b0;
                if (pend_vld) begin
                    push_w      = flush_w;
                    extra_vld_n = 1'b1;
                    extra_w_n   = {wa, pack_word(PAD_BYTE, ioctl_data, BYTE_SWAP)};
                end else begin
                    push_w = {wa, pack_word(PAD_BYTE, ioctl_data, BYTE_SWAP)};
                end
            end
        end else if (!ioctl_download && pend_vld && !fifo_full) begin
            // Download ended with half a word buffered.
            push_req   = 1'b1;
            push_w     = flush_w;
            pend_vld_n = 1'b0;
        end
    end

    // Assembler registers, download edge tracking and highest written address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_vld  <= 1'b0;
            pend_a    <= '0;
            pend_d    <= '0;
            extra_vld <= 1'b0;
            extra_w   <= '0;
            dl_q      <= 1'b0;
            rom_end   <= '0;
        end else begin
            pend_vld  <= pend_vld_n;
            pend_a    <= pend_a_n;
            pend_d    <= pend_d_n;
            extra_vld <= extra_vld_n;
            extra_w   <= extra_w_n;
            dl_q      <= ioctl_download;
            rom_end   <= (push_ok && push_w.addr > end_base) ? push_w.addr : end_base;
        end
    end

    rom_loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(rom_word_t))
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_ok),
        .push_data (push_w),
        .pop       (pop),
        .pop_data  (head_w),
        .count     (fifo_cnt),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Issuer FSM: one outstanding toggle request; req tracks ack while in reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            romwr_req <= romwr_ack;
            romwr_a   <= '0;
            romwr_d   <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    romwr_a   <= head_w.addr;
                    romwr_d   <= head_w.data;
                    romwr_req <= ~romwr_req;
                    state     <= WAIT_ACK;
                end
                WAIT_ACK: if (romwr_ack == romwr_req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Registered busy flag and its falling-edge completion pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            loading   <= 1'b0;
            load_done <= 1'b0;
        end else begin
            loading   <= ld_now;
            load_done <= loading & ~ld_now;
        end
    end

endmodule
